// File: rtl/shiftreg_collect_pkg.sv
// rtl/shiftreg_collect_pkg.sv - shared state type and width helpers for the word collector
package shiftreg_collect_pkg;

   typedef enum logic {ST_FILL, ST_FULL} state_t;

   function automatic int calc_cbits(input int n);
      return $clog2(n);
   endfunction

   function automatic int calc_kbits(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shiftreg_collect_if.sv
// rtl/shiftreg_collect_if.sv - word stream in, assembled vector out
interface shiftreg_collect_if
   import shiftreg_collect_pkg::*;
#(
   parameter int nbits  = 8,
   parameter int nwords = 8
);
   localparam int kbits = calc_kbits(nwords);

   logic             in_valid;
   logic             in_ready;
   logic [nbits-1:0] in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ack;
   logic [nbits-1:0] q_all [nwords-1:0];
   logic [kbits-1:0] out_count;

   modport master (
      output in_valid, in_data, flush, out_ack,
      input  in_ready, out_valid, q_all, out_count
   );

   modport slave (
      input  in_valid, in_data, flush, out_ack,
      output in_ready, out_valid, q_all, out_count
   );

endinterface

// File: rtl/shiftreg_collect.sv
// rtl/shiftreg_collect.sv - collects nwords serial words into a parallel vector for the PISO register
// A flush closes a partial vector, zero-padding the unused upper slots.
module shiftreg_collect
   import shiftreg_collect_pkg::*;
#(
   parameter int nbits  = 8,
   parameter int nwords = 8
)(
   input  logic               clk,
   input  logic               rst,
   shiftreg_collect_if.slave  bus
);
   localparam int cbits = calc_cbits(nwords);
   localparam int kbits = calc_kbits(nwords);
   localparam logic [cbits-1:0] C_LAST = cbits'(nwords - 1);

   generate
      if (nwords < 2) begin : g_bad_nwords
         $error("shiftreg_collect: nwords must be at least 2");
      end
   endgenerate

   state_t           r_state;
   logic [cbits-1:0] r_cnt;
   logic             r_out_valid;
   logic [kbits-1:0] r_out_count;
   logic [nbits-1:0] r_data [nwords-1:0];

   logic             w_in_ready;
   logic             w_accept;
   logic             w_last;
   logic             w_close;
   logic [kbits-1:0] w_post;

   always_comb begin
      w_in_ready = (r_state == ST_FILL) || bus.out_ack;
      w_accept   = bus.in_valid && w_in_ready;
      w_post     = kbits'(r_cnt) + kbits'(w_accept);
      w_last     = (r_state == ST_FILL) && w_accept && (r_cnt == C_LAST);
      w_close    = (r_state == ST_FILL) && bus.flush && (w_post != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_FILL;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_count <= '0;
         for (int i = 0; i < nwords; i++) r_data[i] <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               // Pad slots sit strictly above the accepted slot, so the two writes never collide.
               for (int i = 0; i < nwords; i++) begin
                  if (w_accept && (i == int'(r_cnt)))
                     r_data[i] <= bus.in_data;
                  else if (w_close && (i >= int'(w_post)))
                     r_data[i] <= '0;
               end
               if (w_last || w_close) begin
                  r_state     <= ST_FULL;
                  r_out_valid <= 1'b1;
                  r_out_count <= w_post;
                  r_cnt       <= '0;
               end else if (w_accept) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_FULL: begin
               if (bus.out_ack) begin
                  r_state     <= ST_FILL;
                  r_out_valid <= 1'b0;
                  if (bus.in_valid) begin
                     r_data[0] <= bus.in_data;
                     r_cnt     <= cbits'(1);
                  end else begin
                     r_cnt <= '0;
                  end
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_count = r_out_count;
   assign bus.q_all     = r_data;

endmodule

// File: tb/tb_shiftreg_collect.sv
// tb/tb_shiftreg_collect.sv - directed and random checks of shiftreg_collect against a queue model
module tb_shiftreg_collect;
   localparam int NB = 8;
   localparam int NW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shiftreg_collect_if #(.nbits(NB), .nwords(NW)) bus ();

   shiftreg_collect #(.nbits(NB), .nwords(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [NB-1:0] pend [$];
   bit            m_full;
   logic [NB-1:0] m_vec [NW];
   int            m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic emit();
      for (int i = 0; i < NW; i++) m_vec[i] = (i < pend.size()) ? pend[i] : '0;
      m_cnt  = pend.size();
      m_full = 1'b1;
      pend.delete();
   endtask

   task automatic model_reset();
      pend.delete();
      m_full = 1'b0;
      m_cnt  = 0;
   endtask

   // One clock: drive inputs, check in_ready, advance the model, check registered outputs.
   task automatic cycle(input bit v, input logic [NB-1:0] d, input bit f, input bit a);
      bit acc;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.flush    = f;
      bus.out_ack  = a;
      #1;
      chk("in_ready", bus.in_ready, !m_full || a);
      acc = v && (!m_full || a);
      if (!m_full) begin
         if (acc) pend.push_back(d);
         if (pend.size() == NW || (f && pend.size() > 0)) emit();
      end else if (a) begin
         m_full = 1'b0;
         if (v) pend.push_back(d);
      end
      @(posedge clk);
      #1;
      chk("out_valid", bus.out_valid, m_full);
      if (m_full) begin
         chk("out_count", bus.out_count, m_cnt);
         for (int i = 0; i < NW; i++) chk($sformatf("q_all[%0d]", i), bus.q_all[i], m_vec[i]);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_out_count"}, bus.out_count, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
      for (int i = 0; i < NW; i++) chk($sformatf("%s_q%0d", tag, i), bus.q_all[i], 0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.flush    = 1'b0;
      bus.out_ack  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_cleared("reset");
      rst = 1'b0;

      cycle(1, 8'h11, 0, 0);
      cycle(1, 8'h22, 0, 0);
      cycle(1, 8'h33, 0, 0);
      cycle(1, 8'h44, 0, 0);
      chk("first_q0", bus.q_all[0], 8'h11);
      chk("first_q3", bus.q_all[3], 8'h44);
      chk("first_count", bus.out_count, 4);

      repeat (5) cycle(1, NB'($urandom), 0, 0);
      cycle(1, 8'h55, 0, 1);
      cycle(1, 8'h66, 0, 0);
      cycle(1, 8'h77, 0, 0);
      cycle(1, 8'h88, 0, 0);
      chk("refill_q0", bus.q_all[0], 8'h55);
      cycle(0, 8'h00, 0, 1);

      cycle(1, 8'hA1, 0, 1);
      cycle(1, 8'hA2, 0, 0);
      cycle(0, 8'h00, 1, 0);
      chk("flush_count", bus.out_count, 2);
      chk("flush_q2", bus.q_all[2], 8'h00);
      cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 0, 1);

      cycle(1, 8'hB1, 0, 0);
      cycle(1, 8'hB2, 1, 0);
      chk("flushacc_q1", bus.q_all[1], 8'hB2);
      cycle(0, 8'h00, 0, 1);
      cycle(0, 8'h00, 1, 0);
      chk("empty_flush", bus.out_valid, 1'b0);

      cycle(1, 8'hC1, 0, 0);
      cycle(1, 8'hC2, 0, 0);
      cycle(1, 8'hC3, 1, 0);
      cycle(0, 8'h00, 0, 1);

      cycle(1, 8'hD1, 0, 0);
      cycle(1, 8'hD2, 0, 0);
      cycle(1, 8'hD3, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk_cleared("async_rst");
      model_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      @(posedge clk);
      #1;
      chk_cleared("rst_hold");
      rst = 1'b0;
      cycle(1, 8'hE1, 0, 0);
      cycle(1, 8'hE2, 0, 0);
      cycle(1, 8'hE3, 0, 0);
      cycle(1, 8'hE4, 0, 0);
      chk("post_rst_q0", bus.q_all[0], 8'hE1);
      chk("post_rst_q3", bus.q_all[3], 8'hE4);

      for (int k = 0; k < 12; k++) cycle(1, NB'(8'h20 + k), 0, m_full);
      cycle(0, 8'h00, 0, 1);

      for (int k = 0; k < 400; k++)
         cycle($urandom_range(0, 3) != 0, NB'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shiftreg_collect.md
Name: shiftreg_collect

Overview:
- Serial-in parallel-out word collector that sits directly upstream of the PISO shift register.
- Accepts a stream of nbits words over a valid/ready handshake and assembles nwords of them into a vector.
- Presents the vector on a parallel bus with out_valid, which the downstream register loads using its write-enable.
- A flush input closes out a partial vector by zero-padding it, so the last short group of a sumcheck layer can still be emitted.

Parameters:
- nbits, 8, width of each word.
- nwords, 8, words per output vector; must be at least 2 (generate-time error otherwise).
- cbits, $clog2(nwords), derived: write-index width.
- kbits, $clog2(nwords+1), derived: out_count width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  nbits  serial word.
- flush  input  1  close the current partial vector.
- out_valid  output  1  vector complete and held stable.
- out_ack  input  1  consumer has taken the vector (drives the downstream wren).
- q_all  output  nbits x nwords (unpacked [nwords-1:0])  assembled vector; word 0 arrives first.
- out_count  output  kbits  number of real (non-pad) words in q_all, 1..nwords.

Behaviour:
- A word is accepted on a rising clk edge when in_valid && in_ready.
- State machine, FILL and FULL:
  - FILL: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=out_ack (pass-through refill).
- FILL, word accepted: data_reg[cnt] <= in_data.
  - If cnt==nwords-1: go to FULL, out_count<=nwords, cnt<=0.
  - Otherwise cnt<=cnt+1.
- FILL, flush with at least one word held (cnt>0, or a word accepted the same cycle):
  - Go to FULL.
  - Slots at or above the post-accept count are written 0.
  - out_count <= post-accept count; cnt <= 0.
- FILL, flush with cnt==0 and no word accepted: ignored; stay in FILL.
- FILL, flush on the same cycle as the nwords-th word: identical to a normal completion; out_count=nwords.
- FULL: q_all and out_count are held stable until out_ack.
- FULL, out_ack:
  - Go to FILL.
  - If in_valid on the same cycle, that word is written to slot 0 and cnt<=1.
  - Otherwise cnt<=0.
- flush while in FULL: ignored.
- out_ack while in FILL: ignored.
- Latency: out_valid rises the cycle after the final word, or after flush, is accepted. Throughput is one vector per nwords cycles with no bubble when out_ack comes back immediately.
- q_all in FILL shows the partially filled register contents; they are don't-care to the consumer.
- Reset, applied asynchronously at any time including mid-vector:
  - State FILL, cnt 0.
  - All data_reg slots 0, so q_all is all zero.
  - out_valid 0, out_count 0.
  - in_ready reads 1, but no word is captured while rst is high.
  - Partial data is discarded.
- Arithmetic: cnt increments unsigned and never wraps past nwords-1. out_count is written from cnt+accept zero-extended to kbits.

Decomposition:
- Shared package holds:
  - the state typedef (enum logic {ST_FILL, ST_FULL});
  - the cbits/kbits width helper functions, reused by shiftreg_simple's controller.
- No sub-module; the counter and FSM are small enough to live inline. One comb block plus one ff block.

Test Plan:
- nbits=8, nwords=4. After reset, stream 0x11,0x22,0x33,0x44 on consecutive cycles -> out_valid next cycle; q_all[0..3]=11,22,33,44; out_count=4; in_ready=0.
- Hold out_ack low 5 cycles with in_valid=1 -> q_all stable, no word accepted. Then ack with in_data=0x55 -> FILL, slot0=0x55, cnt=1, no lost cycle.
- Send 0xA1,0xA2, then flush alone -> FULL; q_all=A1,A2,00,00; out_count=2.
- Send 0xB1, then flush on the same cycle as 0xB2 -> q_all=B1,B2,00,00; out_count=2. Flush with empty FILL -> no state change.
- Send 3 words, assert rst mid-cycle (asynchronously) -> out_valid=0 and q_all all 0 immediately. After release, 4 new words produce the correct vector with no stale data.
- Back-to-back: 12 words continuous with out_ack tied to out_valid -> 3 vectors, in_ready stays 1 throughout, vector contents in arrival order.
